// File: rtl/if_fetch_stage.sv
// Instruction fetch stage: PC register, next-PC selection,
// and the IF/ID pipeline register with wrong-path squash.
module if_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0040_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch,
  input  logic [1:0]       pc_sel,
  input  logic [31:0]      id_pc4,
  input  logic [15:0]      id_imm16,
  input  logic [25:0]      id_index26,
  input  logic [31:0]      id_rs_reg,
  input  logic             stall,
  output logic [31:0]      imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ready,
  output logic [31:0]      if_id_instr,
  output logic [31:0]      if_id_pc4,
  output logic             if_id_valid,
  output logic             pc_misalign,
  output logic [CNT_W-1:0] redirect_cnt
);

  logic [31:0] pc;
  logic [31:0] pc4;
  logic [31:0] target;
  logic [31:0] br_off;
  logic        redirect;
  logic        jr_bad;

  assign imem_addr = pc;
  assign pc4       = pc + 32'd4;
  assign br_off    = {{14{id_imm16[15]}}, id_imm16, 2'b00};

  // A branch seen under stall is dropped; ID re-issues it later.
  assign redirect = branch & ~stall & (pc_sel != 2'b00);
  assign jr_bad   = redirect & (pc_sel == 2'b11)
                  & (|id_rs_reg[1:0]);

  always_comb begin
    target = pc4;
    case (pc_sel)
      2'b01:   target = id_pc4 + br_off;
      2'b10:   target = {id_pc4[31:28], id_index26, 2'b00};
      2'b11:   target = {id_rs_reg[31:2], 2'b00};
      default: target = pc4;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      pc           <= RESET_PC;
      if_id_instr  <= '0;
      if_id_pc4    <= '0;
      if_id_valid  <= 1'b0;
      pc_misalign  <= 1'b0;
      redirect_cnt <= '0;
    end else begin
      pc_misalign <= jr_bad;
      if (stall) begin
        pc <= pc;
      end else if (redirect) begin
        pc           <= target;
        if_id_instr  <= '0;
        if_id_pc4    <= '0;
        if_id_valid  <= 1'b0;
        redirect_cnt <= redirect_cnt + 1'b1;
      end else if (!imem_ready) begin
        if_id_instr <= '0;
        if_id_pc4   <= '0;
        if_id_valid <= 1'b0;
      end else begin
        pc          <= pc4;
        if_id_instr <= imem_rdata;
        if_id_pc4   <= pc4;
        if_id_valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_if_fetch_stage.sv
// Scoreboarded bench for if_fetch_stage: directed scenarios
// followed by randomized traffic against a reference model.
module tb_if_fetch_stage;

  localparam logic [31:0] RPC = 32'h0040_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        branch;
  logic [1:0]  pc_sel;
  logic [31:0] id_pc4;
  logic [15:0] id_imm16;
  logic [25:0] id_index26;
  logic [31:0] id_rs_reg;
  logic        stall;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ready;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        pc_misalign;
  logic [15:0] redirect_cnt;

  int errors = 0;
  int checks = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
    logic [15:0] cnt;
  } st_t;

  st_t m;
  st_t q[$];

  always #5 clk = ~clk;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return ~a ^ 32'h5A5A_1234;
  endfunction

  assign imem_rdata = tag(imem_addr);

  if_fetch_stage #(.RESET_PC(RPC), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .branch(branch), .pc_sel(pc_sel),
    .id_pc4(id_pc4), .id_imm16(id_imm16),
    .id_index26(id_index26), .id_rs_reg(id_rs_reg),
    .stall(stall), .imem_addr(imem_addr),
    .imem_rdata(imem_rdata), .imem_ready(imem_ready),
    .if_id_instr(if_id_instr), .if_id_pc4(if_id_pc4),
    .if_id_valid(if_id_valid), .pc_misalign(pc_misalign),
    .redirect_cnt(redirect_cnt)
  );

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, act, exp, $time);
    end
  endtask

  // Reference: next architectural state from current inputs.
  function automatic st_t step(input st_t s);
    st_t n = s;
    logic        take;
    logic [31:0] tgt;
    if (!rst) begin
      n.pc = RPC; n.instr = 0; n.pc4 = 0;
      n.valid = 0; n.mis = 0; n.cnt = 0;
      return n;
    end
    take = branch && !stall && pc_sel != 0;
    tgt = 0;
    if (pc_sel == 1)
      tgt = id_pc4 + 32'($signed(id_imm16)) * 4;
    else if (pc_sel == 2)
      tgt = (id_pc4 & 32'hF000_0000) | (32'(id_index26) << 2);
    else if (pc_sel == 3)
      tgt = id_rs_reg & ~32'd3;
    n.mis = take && pc_sel == 3 && (id_rs_reg % 4 != 0);
    if (stall) begin
    end else if (take) begin
      n.pc = tgt; n.instr = 0; n.pc4 = 0; n.valid = 0;
      n.cnt = s.cnt + 1;
    end else if (!imem_ready) begin
      n.instr = 0; n.pc4 = 0; n.valid = 0;
    end else begin
      n.instr = tag(s.pc);
      n.pc4 = s.pc + 4;
      n.valid = 1;
      n.pc = s.pc + 4;
    end
    return n;
  endfunction

  // Monitor: compare DUT state after every edge against queue head.
  always @(posedge clk) begin
    st_t e;
    #1;
    if (q.size() != 0) begin
      e = q.pop_front();
      chk("sb_pc", imem_addr, e.pc);
      chk("sb_instr", if_id_instr, e.instr);
      chk("sb_pc4", if_id_pc4, e.pc4);
      chk("sb_valid", 32'(if_id_valid), 32'(e.valid));
      chk("sb_mis", 32'(pc_misalign), 32'(e.mis));
      chk("sb_cnt", 32'(redirect_cnt), 32'(e.cnt));
    end
  end

  task automatic cyc(input logic r, input logic b,
                     input logic [1:0] sel, input logic [31:0] p4,
                     input logic [15:0] imm, input logic [25:0] idx,
                     input logic [31:0] rs, input logic st,
                     input logic rdy);
    @(negedge clk);
    rst = r; branch = b; pc_sel = sel; id_pc4 = p4;
    id_imm16 = imm; id_index26 = idx; id_rs_reg = rs;
    stall = st; imem_ready = rdy;
    m = step(m);
    q.push_back(m);
    @(posedge clk);
    #2;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++)
      cyc(1, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  logic [31:0] hold;

  initial begin
    rst = 0; branch = 0; pc_sel = 0; id_pc4 = 0;
    id_imm16 = 0; id_index26 = 0; id_rs_reg = 0;
    stall = 0; imem_ready = 1;
    m = '{pc: 0, instr: 0, pc4: 0, valid: 0, mis: 0, cnt: 0};

    // Reset then sequential fetch
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 1);
    chk("rst_pc", imem_addr, 32'h0040_0000);
    chk("rst_valid", 32'(if_id_valid), 0);
    chk("rst_cnt", 32'(redirect_cnt), 0);
    run(1);
    chk("seq_pc1", imem_addr, 32'h0040_0004);
    chk("seq_pc4", if_id_pc4, 32'h0040_0004);
    chk("seq_valid", 32'(if_id_valid), 1);
    run(1);
    chk("seq_pc2", imem_addr, 32'h0040_0008);

    // Taken beq backwards
    cyc(1, 1, 2'b01, 32'h0040_0008, 16'hFFFE, 0, 0, 0, 1);
    chk("beq_pc", imem_addr, 32'h0040_0000);
    chk("beq_bubble", 32'(if_id_valid), 0);
    chk("beq_cnt", 32'(redirect_cnt), 1);
    run(1);
    chk("beq_tgt_pc4", if_id_pc4, 32'h0040_0004);
    chk("beq_tgt_valid", 32'(if_id_valid), 1);

    // Stall with branch pending, then jump on release
    hold = imem_addr;
    cyc(1, 1, 2'b10, 32'h9000_0000, 0, 26'h010_0003, 0, 1, 1);
    cyc(1, 1, 2'b10, 32'h9000_0000, 0, 26'h010_0003, 0, 1, 1);
    chk("stall_pc", imem_addr, hold);
    chk("stall_cnt", 32'(redirect_cnt), 1);
    chk("stall_pc4", if_id_pc4, 32'h0040_0004);
    cyc(1, 1, 2'b10, 32'h9000_0000, 0, 26'h010_0003, 0, 0, 1);
    chk("jump_pc", imem_addr, 32'h9040_000C);
    chk("jump_cnt", 32'(redirect_cnt), 2);

    // Misaligned jr
    cyc(1, 1, 2'b11, 0, 0, 0, 32'h0040_0013, 0, 1);
    chk("jr_pc", imem_addr, 32'h0040_0010);
    chk("jr_mis", 32'(pc_misalign), 1);
    run(1);
    chk("jr_mis_pulse", 32'(pc_misalign), 0);

    // Memory wait with redirect in the middle
    hold = imem_addr;
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wait_hold", imem_addr, hold);
    chk("wait_bubble", 32'(if_id_valid), 0);
    cyc(1, 1, 2'b01, 32'h0040_0100, 16'h0004, 0, 0, 0, 0);
    chk("wait_redir", imem_addr, 32'h0040_0110);
    chk("wait_bubble2", 32'(if_id_valid), 0);
    cyc(1, 0, 0, 0, 0, 0, 0, 0, 0);
    chk("wait_bubble3", 32'(if_id_valid), 0);
    run(1);
    chk("wait_instr", if_id_instr, tag(32'h0040_0110));

    // PC wrap at top of address space
    cyc(1, 1, 2'b11, 0, 0, 0, 32'hFFFF_FFFC, 0, 1);
    run(1);
    chk("wrap_pc", imem_addr, 32'h0000_0000);

    // Reset on the same edge as a redirect
    cyc(0, 1, 2'b01, 32'h1000_0000, 16'h0040, 0, 0, 0, 1);
    chk("rstmid_pc", imem_addr, RPC);
    chk("rstmid_valid", 32'(if_id_valid), 0);
    chk("rstmid_cnt", 32'(redirect_cnt), 0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      cyc(($urandom_range(0, 49) != 0),
          ($urandom_range(0, 2) == 0),
          2'($urandom_range(0, 3)),
          $urandom, 16'($urandom), 26'($urandom),
          $urandom,
          ($urandom_range(0, 4) == 0),
          ($urandom_range(0, 3) != 0));
    end

    repeat (2) @(posedge clk);
    #3;
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
